// File: rtl/s2p_pkg.sv
// s2p_pkg: shared types and constants for the serial-to-parallel receiver.
//   s2p_state_t     : receiver FSM states (ARM, IDLE, SHIFT)
//   S2P_SYNC_STAGES : depth of the input synchronizers
// Optional feature macro: S2P_PARITY_EN (adds the odd-parity helper).
package s2p_pkg;

  typedef enum logic [1:0] {
    ARM   = 2'd0,
    IDLE  = 2'd1,
    SHIFT = 2'd2
  } s2p_state_t;

  localparam int S2P_SYNC_STAGES = 2;

`ifdef S2P_PARITY_EN
  // True when payload plus parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [32:0] frame_bits);
    return ^frame_bits;
  endfunction
`endif

endpackage

// File: rtl/s2p_receiver_sync_edge.sv
// sync_edge: multi-flop synchronizer with registered edge strobes.
//   clk, rst : system clock, asynchronous active-high reset
//   d        : asynchronous input
//   level    : synchronized level, aligned with the edge strobes
//   rise     : one-cycle strobe on a synchronized 0->1 transition
//   fall     : one-cycle strobe on a synchronized 1->0 transition
// RST_VAL sets the level the chain assumes during reset, so a signal that
// is already high at reset release does not produce a spurious edge.
module sync_edge
  import s2p_pkg::*;
#(
  parameter int   STAGES  = S2P_SYNC_STAGES,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              last_r;
  logic              rise_r;
  logic              fall_r;
  logic              sync_s;

  assign sync_s = sync_r[STAGES-1];

  // Synchronizer chain, previous-level flop and registered edge strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {STAGES{RST_VAL}};
      last_r <= RST_VAL;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
      last_r <= sync_s;
      rise_r <= sync_s & ~last_r;
      fall_r <= ~sync_s & last_r;
    end
  end

  assign level = last_r;
  assign rise  = rise_r;
  assign fall  = fall_r;

endmodule

// File: rtl/s2p_receiver.sv
// s2p_receiver: samples an external shift clock / data / frame link in the
// clk domain and assembles one DATA_BITS-wide word per frame.
//   clk, rst : system clock, asynchronous active-high reset
//   s_clk    : external shift clock (data taken on its rising edge)
//   s_dat    : external serial data
//   s_frm    : external frame enable, high for the whole frame
//   data_out : last good word, held until the next good frame
//   valid    : one-cycle pulse when data_out updates
//   err      : one-cycle pulse on a bad frame (wrong length/overrun/parity)
//   busy     : high while a frame is being shifted in
// Optional feature macro: S2P_PARITY_EN (one odd-parity bit after payload).
module s2p_receiver
  import s2p_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_clk,
  input  logic                 s_dat,
  input  logic                 s_frm,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 err,
  output logic                 busy
);

`ifdef S2P_PARITY_EN
  localparam int EXP_LEN = DATA_BITS + 1;
`else
  localparam int EXP_LEN = DATA_BITS;
`endif
  localparam int CNT_MAX = DATA_BITS + 2;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  s2p_state_t                 state_r;
  logic [CNT_W-1:0]           cnt_r;
  logic [CNT_W-1:0]           cnt_inc_s;
  logic [CNT_W-1:0]           cnt_nx_s;
  logic [EXP_LEN-1:0]         sh_r;
  logic [EXP_LEN-1:0]         sh_shift_s;
  logic [EXP_LEN-1:0]         sh_nx_s;
  logic                       ovr_r;
  logic                       ovr_nx_s;
  logic                       good_s;
  logic [DATA_BITS-1:0]       payload_s;
  logic [DATA_BITS-1:0]       data_r;
  logic                       valid_r;
  logic                       err_r;
  logic                       busy_r;
  logic [S2P_SYNC_STAGES-1:0] dat_sync_r;
  logic                       dat_s;
  logic                       clk_lvl_s;
  logic                       clk_rise_s;
  logic                       clk_fall_s;
  logic                       frm_lvl_s;
  logic                       frm_rise_s;
  logic                       frm_fall_s;
  logic                       unused_ok_s;

  sync_edge #(.STAGES(S2P_SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
    .clk(clk), .rst(rst), .d(s_clk),
    .level(clk_lvl_s), .rise(clk_rise_s), .fall(clk_fall_s)
  );

  // Frame sync resets high: a frame already running at reset release
  // shows no rising edge and is skipped by ARM.
  sync_edge #(.STAGES(S2P_SYNC_STAGES), .RST_VAL(1'b1)) u_sync_frm (
    .clk(clk), .rst(rst), .d(s_frm),
    .level(frm_lvl_s), .rise(frm_rise_s), .fall(frm_fall_s)
  );

  assign unused_ok_s = &{1'b0, clk_lvl_s, clk_fall_s};

  // Plain data synchronizer; the s_clk path has one more flop (registered
  // edge), so the bit taken here is the one present at the s_clk edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat_sync_r <= {S2P_SYNC_STAGES{1'b0}};
    end else begin
      dat_sync_r <= {dat_sync_r[S2P_SYNC_STAGES-2:0], s_dat};
    end
  end

  assign dat_s = dat_sync_r[S2P_SYNC_STAGES-1];

  // Post-edge counter, shift register and overrun flag.
  always_comb begin
    cnt_inc_s  = cnt_r;
    sh_shift_s = sh_r;
    cnt_nx_s   = cnt_r;
    sh_nx_s    = sh_r;
    ovr_nx_s   = ovr_r;
    if (cnt_r == CNT_W'(CNT_MAX)) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + CNT_W'(1);
    end
    if (MSB_FIRST != 0) begin
      sh_shift_s = {sh_r[EXP_LEN-2:0], dat_s};
    end else begin
      sh_shift_s = {dat_s, sh_r[EXP_LEN-1:1]};
    end
    if (clk_rise_s) begin
      cnt_nx_s = cnt_inc_s;
      ovr_nx_s = ovr_r | (cnt_inc_s > CNT_W'(EXP_LEN));
      // Bits beyond the expected length are counted but not stored.
      if (cnt_inc_s > CNT_W'(EXP_LEN)) begin
        sh_nx_s = sh_r;
      end else begin
        sh_nx_s = sh_shift_s;
      end
    end else begin
      cnt_nx_s = cnt_r;
      sh_nx_s  = sh_r;
      ovr_nx_s = ovr_r;
    end
  end

  // Frame verdict on post-edge values, so a bit arriving with the frame
  // end still counts toward the length check.
  always_comb begin
    good_s    = 1'b0;
    payload_s = {DATA_BITS{1'b0}};
`ifdef S2P_PARITY_EN
    if (MSB_FIRST != 0) begin
      payload_s = sh_nx_s[DATA_BITS:1];
    end else begin
      payload_s = sh_nx_s[DATA_BITS-1:0];
    end
    good_s = (cnt_nx_s == CNT_W'(EXP_LEN)) && !ovr_nx_s &&
             odd_parity_ok(33'(sh_nx_s));
`else
    payload_s = sh_nx_s;
    good_s    = (cnt_nx_s == CNT_W'(EXP_LEN)) && !ovr_nx_s;
`endif
  end

  // Receiver FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ARM;
      cnt_r   <= {CNT_W{1'b0}};
      sh_r    <= {EXP_LEN{1'b0}};
      ovr_r   <= 1'b0;
      data_r  <= {DATA_BITS{1'b0}};
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      case (state_r)
        ARM: begin
          busy_r <= 1'b0;
          if (!frm_lvl_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= ARM;
          end
        end
        IDLE: begin
          if (frm_rise_s) begin
            cnt_r   <= {CNT_W{1'b0}};
            sh_r    <= {EXP_LEN{1'b0}};
            ovr_r   <= 1'b0;
            state_r <= SHIFT;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        SHIFT: begin
          cnt_r <= cnt_nx_s;
          sh_r  <= sh_nx_s;
          ovr_r <= ovr_nx_s;
          if (frm_fall_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            if (good_s) begin
              data_r  <= payload_s;
              valid_r <= 1'b1;
            end else begin
              err_r <= 1'b1;
            end
          end else begin
            state_r <= SHIFT;
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ARM;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out = data_r;
  assign valid    = valid_r;
  assign err      = err_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_s2p_receiver.sv
// tb_s2p_receiver: self-checking bench for s2p_receiver (DATA_BITS=8).
// Two instances share the serial inputs: MSB-first and LSB-first.
// Works with and without S2P_PARITY_EN defined.
module tb_s2p_receiver;

  localparam int DB = 8;
`ifdef S2P_PARITY_EN
  localparam int EXP = DB + 1;
`else
  localparam int EXP = DB;
`endif

  typedef struct {
    int          n;
    logic [35:0] seq;      // bit sent at step k is seq[n-1-k]
    bit          coin;     // last s_clk rise together with s_frm fall
    bit          exp_v;
    bit          exp_e;
    logic [7:0]  exp_m;
    logic [7:0]  exp_l;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_clk;
  logic          s_dat;
  logic          s_frm;
  logic [DB-1:0] data_m;
  logic [DB-1:0] data_l;
  logic          valid_m, err_m, busy_m;
  logic          valid_l, err_l, busy_l;

  int n_checks = 0;
  int n_fail   = 0;
  int vm_cnt = 0, em_cnt = 0, vl_cnt = 0, el_cnt = 0, both_cnt = 0;

  vec_t        tab[$];
  logic [7:0]  cur_m, cur_l;
  int          r_sel, r_n;
  logic [35:0] r_seq;
  bit          r_coin, r_good;
  logic [7:0]  r_pm, r_pl;
  int          s_vm, s_em, s_vl, s_el;
  logic [35:0] seq5a;

  always #5 clk = ~clk;

  s2p_receiver #(.DATA_BITS(DB), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .s_clk(s_clk), .s_dat(s_dat), .s_frm(s_frm),
    .data_out(data_m), .valid(valid_m), .err(err_m), .busy(busy_m)
  );

  s2p_receiver #(.DATA_BITS(DB), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .s_clk(s_clk), .s_dat(s_dat), .s_frm(s_frm),
    .data_out(data_l), .valid(valid_l), .err(err_l), .busy(busy_l)
  );

  // Count strobe cycles, sampled away from the active edge.
  always @(negedge clk) begin
    if (valid_m) vm_cnt++;
    if (err_m)   em_cnt++;
    if (valid_l) vl_cnt++;
    if (err_l)   el_cnt++;
    if ((valid_m && err_m) || (valid_l && err_l)) both_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: frame verdict and payloads from the bit list alone.
  function automatic void model(input int n, input logic [35:0] seq, output bit good,
                                output logic [7:0] pm, output logic [7:0] pl);
    int   ones;
    logic b;
    ones = 0;
    pm   = 8'h00;
    pl   = 8'h00;
    for (int k = 0; k < n; k++) begin
      b = seq[n-1-k];
      if (b) ones++;
      if (k < DB) begin
        pm[DB-1-k] = b;
        pl[k]      = b;
      end
    end
`ifdef S2P_PARITY_EN
    good = (n == DB + 1) && ((ones % 2) == 1);
`else
    good = (n == DB);
`endif
  endfunction

  // Send bits k0..k1-1 of an n-bit stream; s_clk phases are 5 clk each.
  task automatic clock_bits(input int n, input logic [35:0] seq, input int k0, input int k1, input bit coin);
    for (int k = k0; k < k1; k++) begin
      s_dat = seq[n-1-k];
      repeat (5) @(negedge clk);
      s_clk = 1'b1;
      if (coin && (k == k1 - 1)) s_frm = 1'b0;
      repeat (5) @(negedge clk);
      s_clk = 1'b0;
    end
  endtask

  task automatic run_frame(input string name, input int n, input logic [35:0] seq, input bit coin,
                           input bit exp_v, input bit exp_e, input logic [7:0] exp_m, input logic [7:0] exp_l);
    int v0m, e0m, v0l, e0l, b0;
    v0m = vm_cnt; e0m = em_cnt; v0l = vl_cnt; e0l = el_cnt; b0 = both_cnt;
    s_frm = 1'b1;
    repeat (6) @(negedge clk);
    clock_bits(n, seq, 0, n, coin);
    if (!coin) begin
      repeat (5) @(negedge clk);
      s_frm = 1'b0;
    end
    repeat (12) @(negedge clk);
    check({name, " valid_m"}, 32'(vm_cnt - v0m), 32'(exp_v));
    check({name, " err_m"},   32'(em_cnt - e0m), 32'(exp_e));
    check({name, " data_m"},  32'(data_m), 32'(exp_m));
    check({name, " valid_l"}, 32'(vl_cnt - v0l), 32'(exp_v));
    check({name, " err_l"},   32'(el_cnt - e0l), 32'(exp_e));
    check({name, " data_l"},  32'(data_l), 32'(exp_l));
    check({name, " both"},    32'(both_cnt - b0), 32'd0);
    check({name, " busy"},    32'({busy_m, busy_l}), 32'd0);
  endtask

  initial begin
    rst = 1'b1; s_clk = 1'b0; s_dat = 1'b0; s_frm = 1'b0;
    repeat (3) @(negedge clk);
    check("reset data_m", 32'(data_m), 32'd0);
    check("reset data_l", 32'(data_l), 32'd0);
    check("reset strobes", 32'({valid_m, err_m, valid_l, err_l}), 32'd0);
    check("reset busy", 32'({busy_m, busy_l}), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Directed vectors with hand-derived expectations.
`ifdef S2P_PARITY_EN
    tab.push_back(vec_t'{9,  36'h165, 1'b0, 1'b1, 1'b0, 8'hB2, 8'h4D});
    tab.push_back(vec_t'{8,  36'h0B2, 1'b0, 1'b0, 1'b1, 8'hB2, 8'h4D});
    tab.push_back(vec_t'{10, 36'h2CB, 1'b0, 1'b0, 1'b1, 8'hB2, 8'h4D});
    tab.push_back(vec_t'{9,  36'h1FF, 1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF});
    tab.push_back(vec_t'{9,  36'h002, 1'b0, 1'b1, 1'b0, 8'h01, 8'h80});
    tab.push_back(vec_t'{9,  36'h003, 1'b0, 1'b0, 1'b1, 8'h01, 8'h80});
`else
    tab.push_back(vec_t'{8,  36'h0B2, 1'b0, 1'b1, 1'b0, 8'hB2, 8'h4D});
    tab.push_back(vec_t'{7,  36'h055, 1'b0, 1'b0, 1'b1, 8'hB2, 8'h4D});
    tab.push_back(vec_t'{9,  36'h199, 1'b0, 1'b0, 1'b1, 8'hB2, 8'h4D});
    tab.push_back(vec_t'{8,  36'h0FF, 1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF});
`endif
    for (int i = 0; i < tab.size(); i++) begin
      run_frame($sformatf("vec%0d", i), tab[i].n, tab[i].seq, tab[i].coin,
                tab[i].exp_v, tab[i].exp_e, tab[i].exp_m, tab[i].exp_l);
    end

    // Reset after 4 bits, released with s_frm still high.
    s_frm = 1'b1;
    repeat (6) @(negedge clk);
    clock_bits(8, 36'h0C3, 0, 4, 1'b0);
    repeat (2) @(negedge clk);
    check("midframe busy", 32'(busy_m), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst data_m", 32'(data_m), 32'd0);
    check("midrst data_l", 32'(data_l), 32'd0);
    check("midrst busy", 32'({busy_m, busy_l}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    s_vm = vm_cnt; s_em = em_cnt; s_vl = vl_cnt; s_el = el_cnt;
    clock_bits(8, 36'h0C3, 4, 8, 1'b0);
    repeat (5) @(negedge clk);
    s_frm = 1'b0;
    repeat (12) @(negedge clk);
    check("cut frame strobes", 32'((vm_cnt - s_vm) + (em_cnt - s_em) + (vl_cnt - s_vl) + (el_cnt - s_el)), 32'd0);
    check("cut frame data_m", 32'(data_m), 32'd0);
    seq5a = (EXP == DB) ? 36'h05A : 36'h0B5;
    run_frame("after reset 5A", EXP, seq5a, 1'b0, 1'b1, 1'b0, 8'h5A, 8'h5A);
    cur_m = 8'h5A;
    cur_l = 8'h5A;

    // Randomized frames against the reference model.
    for (int i = 0; i < 40; i++) begin
      r_sel  = $urandom_range(0, 5);
      r_n    = (r_sel <= 2) ? EXP : ((r_sel == 3) ? EXP - 1 : ((r_sel == 4) ? EXP + 1 : EXP + 3));
      r_seq  = {4'($urandom), 32'($urandom)};
      r_coin = ($urandom_range(0, 3) == 0);
      model(r_n, r_seq, r_good, r_pm, r_pl);
      if (r_good) begin
        cur_m = r_pm;
        cur_l = r_pl;
      end
      run_frame($sformatf("rand%0d", i), r_n, r_seq, r_coin, r_good, !r_good, cur_m, cur_l);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/s2p_receiver.md
# s2p_receiver

Serial-to-parallel frame receiver: the receive end of the board's shift-register serial link (the parallel-in/serial-out shift chain that drives external displays and peripherals). It samples an externally generated shift clock, data and frame signal in the `clk` domain and assembles one `DATA_BITS`-wide word per frame. It presents the word with a one-cycle valid strobe, or flags a framing error. It sits between the board I/O pins and the CPU-side register file in the lab top level.

## Interface
- `DATA_BITS`, default 8: payload width per frame, range 2..32.
- `MSB_FIRST`, default 1: 1 = first received bit lands in `data_out[DATA_BITS-1]`; 0 = first bit lands in `data_out[0]`.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `s_clk` in 1: external shift clock, asynchronous to `clk`; data is taken on its rising edge.
- `s_dat` in 1: external serial data, stable around `s_clk` rising edges.
- `s_frm` in 1: external frame enable; high for the duration of a frame.
- `data_out` out `DATA_BITS`: last good word; holds until the next good frame.
- `valid` out 1: one-`clk` pulse when `data_out` updates.
- `err` out 1: one-`clk` pulse on a bad frame; `data_out` is left unchanged.
- `busy` out 1: high while in state SHIFT.

## Operation
- Each of `s_clk`, `s_dat` and `s_frm` passes through a 2-flop synchronizer. `s_clk` and `s_frm` then get a third flop for edge detection.
- States:
  - ARM: after reset, wait for synchronized `s_frm`=0, then go to IDLE. A frame already in progress at reset release is ignored.
  - IDLE: on an `s_frm` rising edge, clear the shift register and bit counter, then go to SHIFT. An `s_clk` edge in the same cycle is ignored.
  - SHIFT: on each `s_clk` rising edge, shift in the synchronized `s_dat` and increment the counter.
    - The counter saturates at `DATA_BITS`+2.
    - If the counter exceeds the expected length, the frame is marked overrun and shifting stops.
    - On an `s_frm` falling edge, go to IDLE and evaluate the frame.
- Frame evaluation: the frame is good when the counter equals the expected length and the frame is not overrun. A good frame loads `data_out` and pulses `valid`; otherwise `err` pulses.
- Expected length is `DATA_BITS`, or `DATA_BITS`+1 when parity is compiled in.
- If an `s_clk` rising edge and an `s_frm` falling edge occur in the same cycle, the bit is accepted first and counts toward the length check.
- `valid` and `err` are never high in the same cycle.
- Reset values: `data_out`=0, `valid`=0, `err`=0, `busy`=0, state=ARM, counter=0.

## Timing
- Input-to-effect latency is a fixed 3 `clk` cycles: 2 synchronizer flops plus 1 edge-detect flop.
  - A bit is in the shift register 3 cycles after its `s_clk` rising edge is registered at the pin flop.
  - `valid`/`err` assert in the cycle the state leaves SHIFT, 3 cycles after the `s_frm` fall is registered.
- `s_clk` high and low phases must each last at least 2 `clk` periods; faster input is out of spec and its behaviour is undefined.
- `s_dat` must be stable for 3 `clk` periods starting at the `s_clk` rising edge. It goes through the same synchronizer depth, so sampling stays aligned with the edge.
- Back-to-back frames: `s_frm` low for at least 2 `clk` periods between frames; then no frame is lost.
- `rst` mid-frame: all outputs clear immediately, the state returns to ARM, and the partial word is discarded.

## Configuration
- `S2P_PARITY_EN` defined: each frame carries one extra odd-parity bit after the payload.
  - The frame is good only when the count equals `DATA_BITS`+1 and the XOR of the payload and the parity bit is 1.
  - A parity failure pulses `err`.
  - The parity bit never appears in `data_out`.
- `S2P_PARITY_EN` undefined: there is no parity bit and no parity logic. A frame of `DATA_BITS`+1 bits is an overrun error.

## Structure
- Package `s2p_pkg`: state enum `s2p_state_t` (ARM, IDLE, SHIFT) and the constant `S2P_SYNC_STAGES`=2.
- Sub-module `sync_edge`: parameterizable synchronizer with registered rising and falling edge outputs. It is instantiated for `s_clk` and `s_frm`. `s_dat` uses a plain 2-flop synchronizer with no edge detection.
- Top `s2p_receiver` holds the FSM, bit counter, shift register, parity check and output registers.

## Test plan
All scenarios use `DATA_BITS`=8 with a 10 ns `clk` and a 100 ns `s_clk` period unless stated otherwise.
- Good frame, MSB first, bits 1,0,1,1,0,0,1,0 → `data_out`=0xB2, `valid` pulses once for 1 cycle, `err` stays 0.
- `MSB_FIRST`=0 with the same bit stream → `data_out`=0x4D.
- Short frame (7 bits) and long frame (9 bits, parity off) → `err` pulses once each, and `data_out` keeps its previous value of 0xB2.
- Assert `rst` after 4 bits, release it with `s_frm` still high → outputs read 0 and that frame produces no `valid`/`err`. The next full frame 0x5A → `valid` pulses and `data_out`=0x5A.
- Last `s_clk` edge coincident with the `s_frm` fall (same `clk` cycle) → the 8th bit is counted and `data_out`=0xFF for an all-ones stream.
- With `S2P_PARITY_EN`:
  - 0x01 followed by parity bit 0 → `valid` pulses and `data_out`=0x01.
  - 0x01 followed by parity bit 1 → `err` pulses.
